// File: rtl/core_mem_pkg.sv
// Shared encodings and helpers for the Selen memory-access stage.
package core_mem_pkg;

   typedef enum logic [1:0] {
      MEM_OP_NONE  = 2'd0,
      MEM_OP_LOAD  = 2'd1,
      MEM_OP_STORE = 2'd2
   } mem_op_e;

   typedef enum logic [1:0] {
      MEM_SIZE_B = 2'd0,
      MEM_SIZE_H = 2'd1,
      MEM_SIZE_W = 2'd2
   } mem_size_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } mem_state_e;

   function automatic logic is_mem(input logic [1:0] op);
      return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
   endfunction

   // Any size code other than B/H is treated as a word access.
   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] off);
      if (size == MEM_SIZE_B)
         return 1'b0;
      else if (size == MEM_SIZE_H)
         return off[0];
      else
         return off != 2'd0;
   endfunction

endpackage

// File: rtl/core_mem_align.sv
// Byte-lane steering: byte enables, store-data shift, load right-align/mask.
module core_mem_align
   import core_mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] sdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [4:0]  sh;
   logic [31:0] rsh;

   assign sh      = {off_i, 3'b000};
   assign rsh     = rdata_i >> sh;
   assign wdata_o = sdata_i << sh;

   always_comb begin
      be_o    = 4'b1111;
      rdata_o = rsh;
      unique case (size_i)
         MEM_SIZE_B: begin
            be_o    = 4'b0001 << off_i;
            rdata_o = {24'd0, rsh[7:0]};
         end
         MEM_SIZE_H: begin
            be_o    = 4'b0011 << off_i;
            rdata_o = {16'd0, rsh[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/core_mem_s.sv
// Memory-access stage: EX result register, L1D handshake with timeout,
// and right-aligned load data for write-back.
module core_mem_s
   import core_mem_pkg::*;
#(
   parameter int L1D_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid_in,
   input  logic [1:0]  mem_mem_op_in,
   input  logic [1:0]  mem_size_in,
   input  logic [31:0] mem_alu_result_in,
   input  logic [31:0] mem_store_data_in,
   input  logic        mem_wb_mux_alu_mem_in,
   input  logic        mem_we_reg_file_in,
   input  logic [2:0]  mem_sx_op_in,
   input  logic [4:0]  mem_rd_in,
   input  logic [31:0] mem_sx_imm_in,
   input  logic [31:0] mem_pc_4_in,
   output logic        l1d_req_out,
   output logic        l1d_we_out,
   output logic [31:0] l1d_addr_out,
   output logic [3:0]  l1d_be_out,
   output logic [31:0] l1d_wdata_out,
   input  logic        l1d_ack_in,
   input  logic [31:0] l1d_rdata_in,
   output logic        mem_stall_out,
   output logic        mem_misalign_out,
   output logic        mem_err_out,
   output logic        wb_wb_mux_alu_mem_out,
   output logic        wb_we_reg_file_out,
   output logic [2:0]  wb_sx_op_out,
   output logic [4:0]  wb_rd_out,
   output logic [31:0] wb_sx_imm_out,
   output logic [31:0] wb_pc_4_out,
   output logic [31:0] wb_alu_result_out,
   output logic [31:0] wb_mem_data_out,
   output logic        wb_ack_out,
   output logic [4:0]  mem2haz_rd_out
);

   localparam logic [7:0] TO = 8'(L1D_TIMEOUT);

   mem_state_e  state_q;
   logic [1:0]  op_q, size_q;
   logic [31:0] addr_q, sdata_q, imm_q, pc4_q, mdata_q;
   logic        mux_q, we_q, mis_q, err_q;
   logic [2:0]  sx_q;
   logic [4:0]  rd_q;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  be;
   logic [31:0] wdata, rdata_al;
   logic        in_wait;

   core_mem_align u_align (
      .size_i  (size_q),
      .off_i   (addr_q[1:0]),
      .sdata_i (sdata_q),
      .rdata_i (l1d_rdata_in),
      .be_o    (be),
      .wdata_o (wdata),
      .rdata_o (rdata_al)
   );

   assign cnt_d = cnt_q + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         size_q  <= '0;
         addr_q  <= '0;
         sdata_q <= '0;
         mux_q   <= 1'b0;
         we_q    <= 1'b0;
         sx_q    <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         pc4_q   <= '0;
         mdata_q <= '0;
         cnt_q   <= '0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               op_q    <= mem_valid_in ? mem_mem_op_in : 2'd0;
               size_q  <= mem_size_in;
               addr_q  <= mem_alu_result_in;
               sdata_q <= mem_store_data_in;
               mux_q   <= mem_wb_mux_alu_mem_in;
               we_q    <= mem_valid_in & mem_we_reg_file_in;
               sx_q    <= mem_sx_op_in;
               rd_q    <= mem_rd_in;
               imm_q   <= mem_sx_imm_in;
               pc4_q   <= mem_pc_4_in;
               mdata_q <= '0;
               cnt_q   <= '0;
               mis_q   <= 1'b0;
               err_q   <= 1'b0;
               if (mem_valid_in && is_mem(mem_mem_op_in)) begin
                  if (misaligned(mem_size_in, mem_alu_result_in[1:0]))
                     mis_q <= 1'b1;
                  else
                     state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (l1d_ack_in) begin
                  if (op_q == MEM_OP_LOAD)
                     mdata_q <= rdata_al;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_d;
                  if (TO != 8'd0 && cnt_d == TO) begin
                     err_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign in_wait = (state_q == S_WAIT);

   // L1D fields are only driven while a request is outstanding.
   assign l1d_req_out   = in_wait;
   assign l1d_we_out    = in_wait & (op_q == MEM_OP_STORE);
   assign l1d_addr_out  = in_wait ? {addr_q[31:2], 2'b00} : '0;
   assign l1d_be_out    = in_wait ? be : '0;
   assign l1d_wdata_out = in_wait ? wdata : '0;

   assign mem_stall_out    = in_wait;
   assign mem_misalign_out = mis_q;
   assign mem_err_out      = err_q;

   assign wb_ack_out            = ~in_wait;
   assign wb_we_reg_file_out    = we_q & ~in_wait & ~mis_q & ~err_q;
   assign wb_wb_mux_alu_mem_out = mux_q;
   assign wb_sx_op_out          = sx_q;
   assign wb_rd_out             = rd_q;
   assign wb_sx_imm_out         = imm_q;
   assign wb_pc_4_out           = pc4_q;
   assign wb_alu_result_out     = addr_q;
   assign wb_mem_data_out       = mdata_q;
   assign mem2haz_rd_out        = rd_q;

endmodule

// File: tb/tb_core_mem_s.sv
// Self-checking bench for core_mem_s: vector table with a scoreboard
// queue, plus hand sequences for reset, idle acks and back-to-back entries.
module tb_core_mem_s;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [1:0]  op, sz;
   logic [31:0] alu, sdata, imm, pc4;
   logic        mux, we;
   logic [2:0]  sx;
   logic [4:0]  rd;
   logic        req, l1we, ack;
   logic [31:0] l1addr, l1wdata, rdata;
   logic [3:0]  l1be;
   logic        stall, mis, err;
   logic        wb_mux, wb_we, wb_ack;
   logic [2:0]  wb_sx;
   logic [4:0]  wb_rd, haz_rd;
   logic [31:0] wb_imm, wb_pc4, wb_alu, wb_md;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   core_mem_s #(.L1D_TIMEOUT(4)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .mem_valid_in          (valid),
      .mem_mem_op_in         (op),
      .mem_size_in           (sz),
      .mem_alu_result_in     (alu),
      .mem_store_data_in     (sdata),
      .mem_wb_mux_alu_mem_in (mux),
      .mem_we_reg_file_in    (we),
      .mem_sx_op_in          (sx),
      .mem_rd_in             (rd),
      .mem_sx_imm_in         (imm),
      .mem_pc_4_in           (pc4),
      .l1d_req_out           (req),
      .l1d_we_out            (l1we),
      .l1d_addr_out          (l1addr),
      .l1d_be_out            (l1be),
      .l1d_wdata_out         (l1wdata),
      .l1d_ack_in            (ack),
      .l1d_rdata_in          (rdata),
      .mem_stall_out         (stall),
      .mem_misalign_out      (mis),
      .mem_err_out           (err),
      .wb_wb_mux_alu_mem_out (wb_mux),
      .wb_we_reg_file_out    (wb_we),
      .wb_sx_op_out          (wb_sx),
      .wb_rd_out             (wb_rd),
      .wb_sx_imm_out         (wb_imm),
      .wb_pc_4_out           (wb_pc4),
      .wb_alu_result_out     (wb_alu),
      .wb_mem_data_out       (wb_md),
      .wb_ack_out            (wb_ack),
      .mem2haz_rd_out        (haz_rd)
   );

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] rdat;
      logic        we;
      logic [4:0]  rd;
      int          dly;
      logic [31:0] eaddr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] md;
      logic        wbwe;
      logic        mis;
      logic        err;
      int          nreq;
   } vec_t;

   vec_t vt[14];
   vec_t sbq[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      valid = 1'b0; op = '0; sz = '0; alu = '0; sdata = '0;
      mux = 1'b0; we = 1'b0; sx = '0; rd = '0; imm = '0; pc4 = '0;
   endtask

   task automatic run(input vec_t v);
      vec_t e;
      int   n;
      @(negedge clk);
      valid = 1'b1; op = v.op; sz = v.sz; alu = v.addr; sdata = v.sd;
      we = v.we; rd = v.rd; sx = v.rd[2:0]; imm = {27'd0, v.rd};
      pc4 = v.addr + 32'd4; mux = (v.op == 2'd0);
      sbq.push_back(v);
      @(negedge clk);
      idle_inputs();
      n = 0;
      while (req && n < 20) begin
         e = sbq[0];
         chk("addr", l1addr, e.eaddr);
         chk("be", {28'd0, l1be}, {28'd0, e.be});
         chk("wdata", l1wdata, e.wd);
         chk("l1we", {31'd0, l1we}, {31'd0, e.op == 2'd2});
         chk("stall", {31'd0, stall}, 32'd1);
         chk("wbwe_wait", {31'd0, wb_we | wb_ack}, 32'd0);
         if (n == e.dly) begin
            ack = 1'b1;
            rdata = e.rdat;
         end
         @(negedge clk);
         ack = 1'b0;
         rdata = '0;
         n++;
      end
      e = sbq.pop_front();
      chk("nreq", n, e.nreq);
      chk("req_end", {31'd0, req}, 32'd0);
      chk("stall_end", {31'd0, stall}, 32'd0);
      chk("wb_ack", {31'd0, wb_ack}, 32'd1);
      chk("wb_we", {31'd0, wb_we}, {31'd0, e.wbwe});
      chk("misalign", {31'd0, mis}, {31'd0, e.mis});
      chk("err", {31'd0, err}, {31'd0, e.err});
      chk("mdata", wb_md, e.md);
      chk("wb_alu", wb_alu, e.addr);
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
      chk("haz_rd", {27'd0, haz_rd}, {27'd0, e.rd});
      chk("wb_pc4", wb_pc4, e.addr + 32'd4);
      chk("wb_imm", wb_imm, {27'd0, e.rd});
      chk("wb_sx", {29'd0, wb_sx}, {29'd0, e.rd[2:0]});
      chk("wb_mux", {31'd0, wb_mux}, {31'd0, e.op == 2'd0});
   endtask

   initial begin
      vt[0]  = '{2'd0, 2'd2, 32'h1234, 32'h0, 32'h0, 1'b1, 5'd5, 0,
                 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0};
      vt[1]  = '{2'd1, 2'd0, 32'h103, 32'h0, 32'h80AABBCC, 1'b1, 5'd6, 0,
                 32'h100, 4'b1000, 32'h0, 32'h80, 1'b1, 1'b0, 1'b0, 1};
      vt[2]  = '{2'd2, 2'd1, 32'h22, 32'hFFFF5678, 32'h0, 1'b0, 5'd7, 2,
                 32'h20, 4'b1100, 32'h56780000, 32'h0, 1'b0, 1'b0, 1'b0, 3};
      vt[3]  = '{2'd1, 2'd2, 32'h101, 32'h0, 32'h0, 1'b1, 5'd8, 0,
                 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0};
      vt[4]  = '{2'd1, 2'd1, 32'h206, 32'h0, 32'h12345678, 1'b1, 5'd9, 1,
                 32'h204, 4'b1100, 32'h0, 32'h1234, 1'b1, 1'b0, 1'b0, 2};
      vt[5]  = '{2'd1, 2'd2, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1, 5'd10, 0,
                 32'h40, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1};
      vt[6]  = '{2'd2, 2'd0, 32'h11, 32'h123456A5, 32'h0, 1'b0, 5'd11, 0,
                 32'h10, 4'b0010, 32'h3456A500, 32'h0, 1'b0, 1'b0, 1'b0, 1};
      vt[7]  = '{2'd2, 2'd2, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 5'd12, 0,
                 32'h8, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b0, 1};
      vt[8]  = '{2'd1, 2'd1, 32'h103, 32'h0, 32'h0, 1'b1, 5'd13, 0,
                 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0};
      vt[9]  = '{2'd2, 2'd1, 32'h21, 32'h1, 32'h0, 1'b0, 5'd14, 0,
                 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 0};
      vt[10] = '{2'd1, 2'd0, 32'h101, 32'h0, 32'h11223344, 1'b1, 5'd15, 0,
                 32'h100, 4'b0010, 32'h0, 32'h33, 1'b1, 1'b0, 1'b0, 1};
      vt[11] = '{2'd0, 2'd0, 32'hFFFF0000, 32'h0, 32'h0, 1'b0, 5'd16, 0,
                 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0};
      vt[12] = '{2'd1, 2'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 5'd17, 99,
                 32'h0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4};
      vt[13] = '{2'd1, 2'd2, 32'h50, 32'h0, 32'h0BADF00D, 1'b1, 5'd18, 3,
                 32'h50, 4'hF, 32'h0, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 4};

      rst_n = 1'b0;
      ack = 1'b0;
      rdata = '0;
      idle_inputs();
      #3;
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_wb_ack", {31'd0, wb_ack}, 32'd1);
      chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
      chk("rst_be", {28'd0, l1be}, 32'd0);
      chk("rst_mdata", wb_md, 32'd0);
      chk("rst_err_mis", {30'd0, err, mis}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk);
      ack = 1'b1;
      rdata = 32'hFFFFFFFF;
      @(negedge clk);
      ack = 1'b0;
      rdata = '0;
      chk("idle_ack_md", wb_md, 32'd0);
      chk("idle_ack_req", {31'd0, req}, 32'd0);
      chk("idle_ack_wback", {31'd0, wb_ack}, 32'd1);

      for (int i = 0; i < 14; i++)
         run(vt[i]);

      @(negedge clk);
      valid = 1'b1; op = 2'd0; alu = 32'hA; rd = 5'd7; we = 1'b1;
      @(negedge clk);
      alu = 32'hB; rd = 5'd8;
      chk("b2b_alu0", wb_alu, 32'hA);
      chk("b2b_we0", {31'd0, wb_we}, 32'd1);
      @(negedge clk);
      idle_inputs();
      chk("b2b_alu1", wb_alu, 32'hB);
      chk("b2b_rd1", {27'd0, wb_rd}, 32'd8);

      @(negedge clk);
      valid = 1'b1; op = 2'd1; sz = 2'd2; alu = 32'h300; we = 1'b1;
      @(negedge clk);
      idle_inputs();
      chk("mid_req", {31'd0, req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, req}, 32'd0);
      chk("mid_rst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ack = 1'b1;
      rdata = 32'hFFFFFFFF;
      @(negedge clk);
      ack = 1'b0;
      chk("post_rst_md", wb_md, 32'd0);
      chk("post_rst_alu", wb_alu, 32'd0);
      chk("post_rst_ack", {31'd0, wb_ack}, 32'd1);
      chk("post_rst_req", {31'd0, req}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
